// File: rtl/bp_resolve_pkg.sv
// Shared types for the branch-prediction resolution controller and its queue.
package bp_resolve_pkg;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

    // A prediction is wrong if either the direction or the next PC differs.
    function automatic logic is_mispredict(input pred_entry_t entry,
                                           input logic        taken,
                                           input logic [31:0] next_pc);
        return (entry.taken != taken) || (entry.target != next_pc);
    endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// Synchronous in-order queue of prediction records; clear wins over push and pop.
module bp_pred_fifo
    import bp_resolve_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  pred_entry_t data_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output pred_entry_t head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    pred_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = push_i & ~full_o & ~clear_i;
    assign w_do_pop  = pop_i & ~empty_o & ~clear_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end

    // The extra pointer bit tells a full queue apart from an empty one.
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count_o = r_wr_ptr - r_rd_ptr;
    assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/bp_resolve_ctrl.sv
// Resolves queued fetch predictions against execute outcomes, redirects fetch
// on a mispredict and keeps saturating branch / mispredict statistics.
module bp_resolve_ctrl
    import bp_resolve_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_pc_i,
    input  logic [31:0]      pred_target_i,
    output logic             pred_ready_o,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    input  logic [31:0]      res_next_pc_i,
    input  logic             flush_i,
    input  logic             clr_cnt_i,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] cnt_branch_o,
    output logic [CNT_W-1:0] cnt_mispred_o,
    output logic             err_o,
    output logic             dbg_state_o,
    output logic [AW:0]      dbg_count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    state_e           w_state_next;
    pred_entry_t      w_head;
    pred_entry_t      w_push_data;
    logic             w_full;
    logic             w_empty;
    logic             w_ready;
    logic             w_push;
    logic             w_res_fire;
    logic             w_res_empty;
    logic             w_mispred;
    logic             w_clear;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_cnt_branch;
    logic [CNT_W-1:0] r_cnt_mispred;
    logic             r_err;

    // Handshake: a record transfers on a clock edge where pred_valid_i and
    // pred_ready_o are both high; pred_valid_i may be held or dropped freely.
    assign w_push      = pred_valid_i & pred_ready_o;
    assign w_push_data = '{taken: pred_taken_i, pc: pred_pc_i, target: pred_target_i};
    assign w_clear     = flush_i | w_mispred;

    bp_pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .data_i  (w_push_data),
        .pop_i   (w_res_fire),
        .clear_i (w_clear),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (dbg_count_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= RUN;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_res_fire   = 1'b0;
        w_res_empty  = 1'b0;
        w_mispred    = 1'b0;
        if (flush_i) begin
            w_state_next = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    w_ready     = ~w_full;
                    w_res_fire  = res_valid_i & ~w_empty;
                    w_res_empty = res_valid_i & w_empty;
                    w_mispred   = w_res_fire &
                                  is_mispredict(w_head, res_taken_i, res_next_pc_i);
                    if (w_mispred) w_state_next = RECOVER;
                end
                RECOVER: w_state_next = RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    assign pred_ready_o = rst_ni & w_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect    <= w_mispred;
            r_redirect_pc <= w_mispred ? res_next_pc_i : 32'h0;
        end
    end

    // Clearing beats a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else if (clr_cnt_i) begin
            r_cnt_branch  <= '0;
            r_cnt_mispred <= '0;
        end else begin
            if (w_res_fire && (r_cnt_branch != CNT_MAX))
                r_cnt_branch <= r_cnt_branch + CNT_ONE;
            if (w_mispred && (r_cnt_mispred != CNT_MAX))
                r_cnt_mispred <= r_cnt_mispred + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni)          r_err <= 1'b0;
        else if (w_res_empty) r_err <= 1'b1;
    end

    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign cnt_branch_o  = r_cnt_branch;
    assign cnt_mispred_o = r_cnt_mispred;
    assign err_o         = r_err;
    assign dbg_state_o   = (r_state == RECOVER);

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Bench for bp_resolve_ctrl: reference queue model, redirect scoreboard and
// directed scenarios, plus a 4-bit-counter instance for saturation.
module tb_bp_resolve_ctrl;
    import bp_resolve_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        pred_valid_i, pred_taken_i, res_valid_i, res_taken_i, flush_i, clr_cnt_i;
    logic [31:0] pred_pc_i, pred_target_i, res_next_pc_i;

    logic        pred_ready_o, redirect_o, err_o, dbg_state_o;
    logic [31:0] redirect_pc_o, cnt_branch_o, cnt_mispred_o;
    logic [AW:0] dbg_count_o;

    logic        c4_pred_ready, c4_redirect, c4_err, c4_dbg_state;
    logic [31:0] c4_redirect_pc;
    logic [3:0]  c4_cnt_branch, c4_cnt_mispred;
    logic [AW:0] c4_dbg_count;

    // reference model state
    pred_entry_t m_q[$];
    logic        m_recover;
    logic [31:0] m_br, m_mp;
    logic [3:0]  m_br4, m_mp4;
    logic        m_err;
    logic [31:0] exp_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    bp_resolve_ctrl #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i),
        .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i), .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_next_pc_i(res_next_pc_i),
        .flush_i(flush_i), .clr_cnt_i(clr_cnt_i),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .cnt_branch_o(cnt_branch_o), .cnt_mispred_o(cnt_mispred_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o), .dbg_count_o(dbg_count_o)
    );

    bp_resolve_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) dut_c4 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i),
        .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i), .pred_ready_o(c4_pred_ready),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_next_pc_i(res_next_pc_i),
        .flush_i(flush_i), .clr_cnt_i(clr_cnt_i),
        .redirect_o(c4_redirect), .redirect_pc_o(c4_redirect_pc),
        .cnt_branch_o(c4_cnt_branch), .cnt_mispred_o(c4_cnt_mispred), .err_o(c4_err),
        .dbg_state_o(c4_dbg_state), .dbg_count_o(c4_dbg_count)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        pred_valid_i = 1'b0; pred_taken_i = 1'b0; pred_pc_i = 32'h0; pred_target_i = 32'h0;
        res_valid_i = 1'b0; res_taken_i = 1'b0; res_next_pc_i = 32'h0;
        flush_i = 1'b0; clr_cnt_i = 1'b0;
    endtask

    // One clock: model the cycle from the driven inputs, check pred_ready_o,
    // then after the edge pop/compare the redirect scoreboard.
    task automatic step();
        logic        m_ready, fire, mis, eres;
        logic [31:0] exp_pc;
        pred_entry_t e;
        #1;
        m_ready = rst_ni && !m_recover && (m_q.size() < DEPTH) && !flush_i;
        fire    = rst_ni && res_valid_i && (m_q.size() > 0) && !m_recover && !flush_i;
        mis     = 1'b0;
        if (fire) mis = (m_q[0].taken != res_taken_i) || (m_q[0].target != res_next_pc_i);
        eres    = rst_ni && res_valid_i && (m_q.size() == 0) && !m_recover && !flush_i;
        tests_run++;
        if (pred_ready_o !== m_ready) begin
            tests_failed++;
            $display("FAIL pred_ready: got %b expected %b at %0t", pred_ready_o, m_ready, $time);
        end
        @(posedge clk_i);
        if (!rst_ni) begin
            m_q.delete(); exp_q.delete();
            m_recover = 1'b0; m_err = 1'b0;
            m_br = '0; m_mp = '0; m_br4 = '0; m_mp4 = '0;
        end else begin
            if (clr_cnt_i) begin
                m_br = '0; m_mp = '0; m_br4 = '0; m_mp4 = '0;
            end else begin
                if (fire && m_br  != 32'hFFFF_FFFF) m_br  = m_br + 32'd1;
                if (fire && m_br4 != 4'hF)          m_br4 = m_br4 + 4'd1;
                if (mis  && m_mp  != 32'hFFFF_FFFF) m_mp  = m_mp + 32'd1;
                if (mis  && m_mp4 != 4'hF)          m_mp4 = m_mp4 + 4'd1;
            end
            if (eres) m_err = 1'b1;
            if (flush_i || mis) begin
                m_q.delete();
            end else begin
                if (fire) void'(m_q.pop_front());
                if (pred_valid_i && m_ready) begin
                    e.taken = pred_taken_i; e.pc = pred_pc_i; e.target = pred_target_i;
                    m_q.push_back(e);
                end
            end
            m_recover = !flush_i && mis;
            if (mis) exp_q.push_back(res_next_pc_i);
        end
        #1;
        if (redirect_o === 1'b1 || exp_q.size() > 0) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL redirect_unexpected: got redirect_o=%b pc=%h, none expected at %0t",
                         redirect_o, redirect_pc_o, $time);
            end else begin
                exp_pc = exp_q.pop_front();
                if (redirect_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
                    tests_failed++;
                    $display("FAIL redirect: got redirect_o=%b pc=%h expected 1 pc=%h at %0t",
                             redirect_o, redirect_pc_o, exp_pc, $time);
                end
            end
        end
    endtask

    task automatic apply_reset();
        idle(); rst_ni = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic push(input logic t, input logic [31:0] pc, input logic [31:0] tgt);
        idle(); pred_valid_i = 1'b1; pred_taken_i = t; pred_pc_i = pc; pred_target_i = tgt;
        step(); idle();
    endtask

    task automatic resolve(input logic t, input logic [31:0] npc);
        idle(); res_valid_i = 1'b1; res_taken_i = t; res_next_pc_i = npc;
        step(); idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); rst_ni = 1'b0;
        step();
        tests_run++; if (pred_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset ready_in_reset: got %b expected 0", pred_ready_o); end
        step();
        tests_run++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin tests_failed++; $display("FAIL reset redirect: got %b/%h expected 0/0", redirect_o, redirect_pc_o); end
        tests_run++; if (cnt_branch_o !== 32'd0 || cnt_mispred_o !== 32'd0) begin tests_failed++; $display("FAIL reset counters: got %0d/%0d expected 0/0", cnt_branch_o, cnt_mispred_o); end
        tests_run++; if (err_o !== 1'b0 || dbg_state_o !== 1'b0 || dbg_count_o !== 3'd0) begin tests_failed++; $display("FAIL reset state: got err=%b st=%b cnt=%0d expected 0/0/0", err_o, dbg_state_o, dbg_count_o); end
        rst_ni = 1'b1;
        #1;
        tests_run++; if (pred_ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset ready_after: got %b expected 1", pred_ready_o); end
    endtask

    task automatic test_correct_taken();
        apply_reset();
        push(1'b1, 32'h100, 32'h80);
        tests_run++; if (dbg_count_o !== 3'd1) begin tests_failed++; $display("FAIL correct_taken occupancy_push: got %0d expected 1", dbg_count_o); end
        resolve(1'b1, 32'h80);
        tests_run++; if (cnt_branch_o !== 32'd1 || cnt_mispred_o !== 32'd0) begin tests_failed++; $display("FAIL correct_taken counters: got %0d/%0d expected 1/0", cnt_branch_o, cnt_mispred_o); end
        tests_run++; if (redirect_o !== 1'b0 || dbg_count_o !== 3'd0) begin tests_failed++; $display("FAIL correct_taken redirect_queue: got %b/%0d expected 0/0", redirect_o, dbg_count_o); end
    endtask

    task automatic test_dir_mispredict();
        apply_reset();
        push(1'b0, 32'h200, 32'h204);
        push(1'b1, 32'h210, 32'h300);
        resolve(1'b1, 32'h240);
        tests_run++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h240) begin tests_failed++; $display("FAIL dir_mispred redirect: got %b/%h expected 1/00000240", redirect_o, redirect_pc_o); end
        tests_run++; if (cnt_mispred_o !== 32'd1 || cnt_branch_o !== 32'd1) begin tests_failed++; $display("FAIL dir_mispred counters: got %0d/%0d expected 1/1", cnt_branch_o, cnt_mispred_o); end
        tests_run++; if (pred_ready_o !== 1'b0 || dbg_state_o !== 1'b1) begin tests_failed++; $display("FAIL dir_mispred recover: got ready=%b st=%b expected 0/1", pred_ready_o, dbg_state_o); end
        // resolve and push during the recovery cycle are both ignored
        pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_pc_i = 32'h244; pred_target_i = 32'h280;
        res_valid_i = 1'b1; res_taken_i = 1'b0; res_next_pc_i = 32'h999;
        step(); idle(); #1;
        tests_run++; if (pred_ready_o !== 1'b1 || dbg_count_o !== 3'd0 || dbg_state_o !== 1'b0) begin tests_failed++; $display("FAIL dir_mispred after: got ready=%b cnt=%0d st=%b expected 1/0/0", pred_ready_o, dbg_count_o, dbg_state_o); end
        tests_run++; if (redirect_o !== 1'b0 || cnt_branch_o !== 32'd1 || err_o !== 1'b0) begin tests_failed++; $display("FAIL dir_mispred ignored_resolve: got redir=%b br=%0d err=%b expected 0/1/0", redirect_o, cnt_branch_o, err_o); end
    endtask

    task automatic test_target_mispredict();
        apply_reset();
        push(1'b1, 32'h300, 32'h400);
        pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_pc_i = 32'h310; pred_target_i = 32'h500;
        res_valid_i = 1'b1; res_taken_i = 1'b1; res_next_pc_i = 32'h404;
        step(); idle();
        tests_run++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h404 || cnt_mispred_o !== 32'd1) begin tests_failed++; $display("FAIL target_mispred: got %b/%h/%0d expected 1/00000404/1", redirect_o, redirect_pc_o, cnt_mispred_o); end
        step();
        tests_run++; if (dbg_count_o !== 3'd0 || redirect_o !== 1'b0) begin tests_failed++; $display("FAIL target_mispred discard: got cnt=%0d redir=%b expected 0/0", dbg_count_o, redirect_o); end
    endtask

    task automatic test_full();
        apply_reset();
        push(1'b0, 32'h100, 32'h104);
        push(1'b1, 32'h110, 32'h200);
        push(1'b0, 32'h120, 32'h124);
        push(1'b1, 32'h130, 32'h300);
        #1;
        tests_run++; if (pred_ready_o !== 1'b0 || dbg_count_o !== 3'd4) begin tests_failed++; $display("FAIL full: got ready=%b cnt=%0d expected 0/4", pred_ready_o, dbg_count_o); end
        pred_valid_i = 1'b1; pred_taken_i = 1'b1; pred_pc_i = 32'h140; pred_target_i = 32'h400;
        res_valid_i = 1'b1; res_taken_i = 1'b0; res_next_pc_i = 32'h104;
        step(); idle();
        tests_run++; if (dbg_count_o !== 3'd3) begin tests_failed++; $display("FAIL full push_pop_refused: got %0d expected 3", dbg_count_o); end
        push(1'b1, 32'h140, 32'h400);
        tests_run++; if (dbg_count_o !== 3'd4) begin tests_failed++; $display("FAIL full next_push: got %0d expected 4", dbg_count_o); end
        resolve(1'b1, 32'h200);
        resolve(1'b0, 32'h124);
        resolve(1'b1, 32'h300);
        resolve(1'b1, 32'h400);
        tests_run++; if (dbg_count_o !== 3'd0 || cnt_branch_o !== 32'd5 || cnt_mispred_o !== 32'd0) begin tests_failed++; $display("FAIL full drain: got cnt=%0d br=%0d mp=%0d expected 0/5/0", dbg_count_o, cnt_branch_o, cnt_mispred_o); end
    endtask

    task automatic test_flush();
        apply_reset();
        push(1'b0, 32'h200, 32'h204);
        push(1'b1, 32'h210, 32'h300);
        flush_i = 1'b1;
        res_valid_i = 1'b1; res_taken_i = 1'b1; res_next_pc_i = 32'h240;
        pred_valid_i = 1'b1; pred_taken_i = 1'b0; pred_pc_i = 32'h220; pred_target_i = 32'h224;
        step(); idle();
        tests_run++; if (redirect_o !== 1'b0 || cnt_branch_o !== 32'd0 || cnt_mispred_o !== 32'd0) begin tests_failed++; $display("FAIL flush: got redir=%b br=%0d mp=%0d expected 0/0/0", redirect_o, cnt_branch_o, cnt_mispred_o); end
        tests_run++; if (dbg_count_o !== 3'd0 || dbg_state_o !== 1'b0) begin tests_failed++; $display("FAIL flush queue: got cnt=%0d st=%b expected 0/0", dbg_count_o, dbg_state_o); end
        step();
        tests_run++; if (redirect_o !== 1'b0 || pred_ready_o !== 1'b1) begin tests_failed++; $display("FAIL flush after: got redir=%b ready=%b expected 0/1", redirect_o, pred_ready_o); end
    endtask

    task automatic test_empty_resolve();
        apply_reset();
        resolve(1'b1, 32'h40);
        tests_run++; if (err_o !== 1'b1 || cnt_branch_o !== 32'd0 || cnt_mispred_o !== 32'd0 || redirect_o !== 1'b0) begin tests_failed++; $display("FAIL empty_resolve: got err=%b br=%0d mp=%0d redir=%b expected 1/0/0/0", err_o, cnt_branch_o, cnt_mispred_o, redirect_o); end
        push(1'b0, 32'h50, 32'h54);
        resolve(1'b0, 32'h54);
        step();
        tests_run++; if (err_o !== 1'b1 || cnt_branch_o !== 32'd1) begin tests_failed++; $display("FAIL empty_resolve sticky: got err=%b br=%0d expected 1/1", err_o, cnt_branch_o); end
        apply_reset();
        tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL empty_resolve reset: got %b expected 0", err_o); end
    endtask

    task automatic test_counters();
        logic [31:0] pc;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            pc = 32'h1000 + 32'(i) * 32'd16;
            push(1'b1, pc, pc + 32'd8);
            resolve(1'b1, pc + 32'd8);
        end
        tests_run++; if (c4_cnt_branch !== 4'd15 || cnt_branch_o !== 32'd16) begin tests_failed++; $display("FAIL counters branch_sat: got c4=%0d c32=%0d expected 15/16", c4_cnt_branch, cnt_branch_o); end
        for (int i = 0; i < 17; i++) begin
            pc = 32'h2000 + 32'(i) * 32'd16;
            push(1'b0, pc, pc + 32'd4);
            resolve(1'b1, pc + 32'h40);
            step();
        end
        tests_run++; if (c4_cnt_mispred !== 4'd15 || cnt_mispred_o !== 32'd17 || cnt_branch_o !== 32'd33) begin tests_failed++; $display("FAIL counters mispred_sat: got c4=%0d c32=%0d br=%0d expected 15/17/33", c4_cnt_mispred, cnt_mispred_o, cnt_branch_o); end
        push(1'b1, 32'h500, 32'h580);
        res_valid_i = 1'b1; res_taken_i = 1'b1; res_next_pc_i = 32'h580; clr_cnt_i = 1'b1;
        step(); idle();
        tests_run++; if (cnt_branch_o !== 32'd0 || cnt_mispred_o !== 32'd0 || c4_cnt_branch !== 4'd0 || c4_cnt_mispred !== 4'd0) begin tests_failed++; $display("FAIL counters clear: got %0d/%0d/%0d/%0d expected 0/0/0/0", cnt_branch_o, cnt_mispred_o, c4_cnt_branch, c4_cnt_mispred); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        push(1'b0, 32'h600, 32'h604);
        push(1'b1, 32'h610, 32'h700);
        resolve(1'b1, 32'h640);
        rst_ni = 1'b0;
        step();
        tests_run++; if (redirect_o !== 1'b0 || dbg_state_o !== 1'b0 || dbg_count_o !== 3'd0 || cnt_mispred_o !== 32'd0) begin tests_failed++; $display("FAIL reset_midflight: got redir=%b st=%b cnt=%0d mp=%0d expected 0/0/0/0", redirect_o, dbg_state_o, dbg_count_o, cnt_mispred_o); end
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            pred_valid_i  = 1'($urandom_range(0, 1));
            pred_taken_i  = 1'($urandom_range(0, 1));
            pred_pc_i     = 32'h4000 + 32'(i) * 32'd4;
            pred_target_i = pred_taken_i ? (32'h8000 + 32'($urandom_range(0, 63)) * 32'd4)
                                         : (pred_pc_i + 32'd4);
            res_valid_i   = ($urandom_range(0, 2) == 0);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                res_taken_i   = m_q[0].taken;
                res_next_pc_i = m_q[0].target;
            end else begin
                res_taken_i   = 1'($urandom_range(0, 1));
                res_next_pc_i = 32'hC000 + 32'($urandom_range(0, 15)) * 32'd4;
            end
            flush_i   = ($urandom_range(0, 39) == 0);
            clr_cnt_i = ($urandom_range(0, 79) == 0);
            step();
            tests_run++;
            if (dbg_count_o !== 3'(m_q.size())) begin
                tests_failed++;
                $display("FAIL back_to_back occupancy: got %0d expected %0d at %0t", dbg_count_o, m_q.size(), $time);
            end
        end
        idle();
        step();
        tests_run++; if (cnt_branch_o !== m_br || cnt_mispred_o !== m_mp) begin tests_failed++; $display("FAIL back_to_back counters: got %0d/%0d expected %0d/%0d", cnt_branch_o, cnt_mispred_o, m_br, m_mp); end
        tests_run++; if (c4_cnt_branch !== m_br4 || c4_cnt_mispred !== m_mp4) begin tests_failed++; $display("FAIL back_to_back counters4: got %0d/%0d expected %0d/%0d", c4_cnt_branch, c4_cnt_mispred, m_br4, m_mp4); end
        tests_run++; if (err_o !== m_err) begin tests_failed++; $display("FAIL back_to_back err: got %b expected %b", err_o, m_err); end
    endtask

    initial begin
        m_recover = 1'b0; m_err = 1'b0;
        m_br = '0; m_mp = '0; m_br4 = '0; m_mp4 = '0;
        idle();
        rst_ni = 1'b0;
        test_reset();
        test_correct_taken();
        test_dir_mispredict();
        test_target_mispredict();
        test_full();
        test_flush();
        test_empty_resolve();
        test_counters();
        test_reset_midflight();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending redirects expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
